// File: rtl/sfifo_pkg.sv
// Shared constants for the single-clock threshold FIFO: default geometry and
// the read-mode selector values for the FWFT parameter.
package sfifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  localparam int RD_STD  = 0;
  localparam int RD_FWFT = 1;

endpackage : sfifo_pkg

// File: rtl/sfifo_mem.sv
// DEPTH x DSIZE dual-port storage: synchronous write, asynchronous read so the
// top level can either register the head word or present it directly.
module sfifo_mem
  import sfifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [DSIZE-1:0] wr_data,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [DSIZE-1:0] rd_data
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : sfifo_mem

// File: rtl/sfifo_thresh.sv
// Single-clock FIFO with run-time almost-full/almost-empty thresholds, a live
// fill level, sticky overflow/underflow flags and a selectable FWFT read mode.
module sfifo_thresh
  import sfifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF,
  parameter int FWFT  = RD_STD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_inc,
  output logic             wr_full,
  output logic             wr_almost_full,
  output logic             wr_overflow,
  output logic [DSIZE-1:0] rd_data,
  input  logic             rd_inc,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic             rd_underflow,
  input  logic [ASIZE:0]   af_thresh,
  input  logic [ASIZE:0]   ae_thresh,
  input  logic             err_clr,
  output logic [ASIZE:0]   fill_level
);

  localparam int             PW      = ASIZE + 1;
  localparam int             DEPTH   = 1 << ASIZE;
  localparam logic [PW-1:0]  DEPTH_W = PW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             wr_ovf_q, wr_ovf_d;
  logic             rd_unf_q, rd_unf_d;
  logic [PW-1:0]    level;
  logic             full, empty;
  logic             wr_accept, rd_accept;
  logic [DSIZE-1:0] mem_rd_data;

  // The extra pointer MSB disambiguates full from empty; the modulo
  // subtraction yields 0..DEPTH directly.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DEPTH_W);
  assign empty = (level == '0);

  assign wr_accept = wr_inc & ~full;
  assign rd_accept = rd_inc & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
    // A set condition on the clearing edge wins over err_clr.
    wr_ovf_d = (wr_ovf_q & ~err_clr) | (wr_inc & full);
    rd_unf_d = (rd_unf_q & ~err_clr) | (rd_inc & empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_ovf_q <= 1'b0;
      rd_unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ovf_q <= wr_ovf_d;
      rd_unf_q <= rd_unf_d;
    end
  end

  sfifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[ASIZE-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[ASIZE-1:0]),
    .rd_data (mem_rd_data)
  );

  generate
    if (FWFT == RD_STD) begin : g_std
      logic [DSIZE-1:0] rd_data_q, rd_data_d;

      assign rd_data_d = rd_accept ? mem_rd_data : rd_data_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_q <= '0;
        end else begin
          rd_data_q <= rd_data_d;
        end
      end

      assign rd_data = rd_data_q;
    end else begin : g_fwft
      // Head word shown directly; forced to zero while empty so stale or
      // uninitialised storage never leaks out (also gives the reset value).
      assign rd_data = empty ? '0 : mem_rd_data;
    end
  endgenerate

  assign fill_level      = level;
  assign wr_full         = full;
  assign rd_empty        = empty;
  assign wr_almost_full  = (level >= af_thresh);
  assign rd_almost_empty = (level <= ae_thresh);
  assign wr_overflow     = wr_ovf_q;
  assign rd_underflow    = rd_unf_q;

endmodule : sfifo_thresh

// File: tb/tb_sfifo_thresh.sv
// Self-checking bench: queue model checked every cycle against a standard-read
// and an FWFT instance sharing the same stimulus, plus literal spot checks.
module tb_sfifo_thresh;

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_inc;
  logic       rd_inc;
  logic       err_clr;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;

  logic       s_full, s_af, s_ovf, s_empty, s_ae, s_unf;
  logic [7:0] s_rd;
  logic [4:0] s_fill;
  logic       f_full, f_af, f_ovf, f_empty, f_ae, f_unf;
  logic [7:0] f_rd;
  logic [4:0] f_fill;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  sfifo_thresh #(.DSIZE(8), .ASIZE(4), .FWFT(0)) dut_std (
    .clk             (clk),
    .rst             (rst),
    .wr_data         (wr_data),
    .wr_inc          (wr_inc),
    .wr_full         (s_full),
    .wr_almost_full  (s_af),
    .wr_overflow     (s_ovf),
    .rd_data         (s_rd),
    .rd_inc          (rd_inc),
    .rd_empty        (s_empty),
    .rd_almost_empty (s_ae),
    .rd_underflow    (s_unf),
    .af_thresh       (af_thresh),
    .ae_thresh       (ae_thresh),
    .err_clr         (err_clr),
    .fill_level      (s_fill)
  );

  sfifo_thresh #(.DSIZE(8), .ASIZE(4), .FWFT(1)) dut_fw (
    .clk             (clk),
    .rst             (rst),
    .wr_data         (wr_data),
    .wr_inc          (wr_inc),
    .wr_full         (f_full),
    .wr_almost_full  (f_af),
    .wr_overflow     (f_ovf),
    .rd_data         (f_rd),
    .rd_inc          (rd_inc),
    .rd_empty        (f_empty),
    .rd_almost_empty (f_ae),
    .rd_underflow    (f_unf),
    .af_thresh       (af_thresh),
    .ae_thresh       (ae_thresh),
    .err_clr         (err_clr),
    .fill_level      (f_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];
  logic       m_ovf, m_unf;
  logic [7:0] m_rd_std;
  bit         m_was_full, m_was_empty;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_rd_std = 8'h00;
    end else begin
      m_was_full  = (q.size() == 16);
      m_was_empty = (q.size() == 0);
      if (rd_inc && !m_was_empty) m_rd_std = q.pop_front();
      if (wr_inc && !m_was_full) q.push_back(wr_data);
      m_ovf = (m_ovf && !err_clr) || (wr_inc && m_was_full);
      m_unf = (m_unf && !err_clr) || (rd_inc && m_was_empty);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("s_fill",  32'(s_fill),  32'(q.size()));
      cmp("s_full",  32'(s_full),  32'(q.size() == 16));
      cmp("s_empty", 32'(s_empty), 32'(q.size() == 0));
      cmp("s_af",    32'(s_af),    32'(q.size() >= int'(af_thresh)));
      cmp("s_ae",    32'(s_ae),    32'(q.size() <= int'(ae_thresh)));
      cmp("s_ovf",   32'(s_ovf),   32'(m_ovf));
      cmp("s_unf",   32'(s_unf),   32'(m_unf));
      cmp("s_rd",    32'(s_rd),    32'(m_rd_std));
      cmp("f_fill",  32'(f_fill),  32'(q.size()));
      cmp("f_flags", {26'd0, f_full, f_empty, f_af, f_ae, f_ovf, f_unf},
                     {26'd0, s_full, s_empty, s_af, s_ae, s_ovf, s_unf});
      cmp("f_rd",    32'(f_rd),    32'(q.size() > 0 ? q[0] : 8'h00));
    end
  end

  // One clock: drive inputs, let the edge happen, return 1 time unit after it.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_inc  = w;
    wr_data = d;
    rd_inc  = r;
    err_clr = c;
    @(posedge clk);
    #1;
    $display("cyc t=%0t w=%0d d=%02h r=%0d c=%0d fill=%0d rd_std=%02h rd_fwft=%02h",
             $time, w, d, r, c, s_fill, s_rd, f_rd);
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    wr_data   = 8'h00;
    wr_inc    = 1'b0;
    rd_inc    = 1'b0;
    err_clr   = 1'b0;
    af_thresh = 5'd14;
    ae_thresh = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    // Reset state
    cmp("rst_empty", 32'(s_empty), 32'd1);
    cmp("rst_fill",  32'(s_fill),  32'd0);
    cmp("rst_rd",    32'(s_rd),    32'd0);
    cmp("rst_ae",    32'(s_ae),    32'd1);
    cmp("rst_af",    32'(s_af),    32'd0);
    cmp("rst_frd",   32'(f_rd),    32'd0);

    // Underflow after reset
    cyc(0, 8'h00, 1, 0);
    cmp("unf_set",  32'(s_unf),  32'd1);
    cmp("unf_rd",   32'(s_rd),   32'd0);
    cmp("unf_fill", 32'(s_fill), 32'd0);
    cyc(0, 8'h00, 0, 1);
    cmp("unf_clr",  32'(s_unf),  32'd0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      if (i == 12) cmp("af_13", 32'(s_af), 32'd0);
      if (i == 13) cmp("af_14", 32'(s_af), 32'd1);
      if (i == 14) cmp("full_15", 32'(s_full), 32'd0);
    end
    cmp("full_16", 32'(s_full), 32'd1);
    cmp("fill_16", 32'(s_fill), 32'd16);

    // Overflow at full, then clear
    cyc(1, 8'hEE, 0, 0);
    cmp("ovf_set",  32'(s_ovf),  32'd1);
    cmp("ovf_fill", 32'(s_fill), 32'd16);
    cyc(0, 8'h00, 0, 1);
    cmp("ovf_clr",  32'(s_ovf),  32'd0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1, 0);
      cmp("drain_rd", 32'(s_rd), 32'(i));
      if (i == 12) cmp("ae_lvl3", 32'(s_ae), 32'd0);
      if (i == 13) cmp("ae_lvl2", 32'(s_ae), 32'd1);
    end
    cmp("drain_empty", 32'(s_empty), 32'd1);

    // Hold level 8, then 40 cycles of simultaneous access across wrap
    for (int k = 0; k < 8; k++) cyc(1, 8'(8'h40 + k), 0, 0);
    for (int k = 0; k < 40; k++) begin
      cyc(1, 8'(8'h48 + k), 1, 0);
      cmp("sim_fill", 32'(s_fill), 32'd8);
      cmp("sim_rd",   32'(s_rd),   32'(8'(8'h40 + k)));
    end
    for (int k = 0; k < 8; k++) cyc(0, 8'h00, 1, 0);
    cmp("sim_last", 32'(s_rd), 32'h6F);

    // Simultaneous at empty: write accepted, read rejected
    cyc(1, 8'h77, 1, 0);
    cmp("se_fill", 32'(s_fill), 32'd1);
    cmp("se_unf",  32'(s_unf),  32'd1);
    cyc(0, 8'h00, 1, 1);
    cmp("se_rd",   32'(s_rd),   32'h77);

    // FWFT: word visible without rd_inc, one pop empties
    cyc(1, 8'hA5, 0, 0);
    cmp("fwft_rd",    32'(f_rd),    32'hA5);
    cmp("fwft_nemp",  32'(f_empty), 32'd0);
    cyc(0, 8'h00, 1, 0);
    cmp("fwft_empty", 32'(f_empty), 32'd1);
    cmp("std_a5",     32'(s_rd),    32'hA5);

    // Threshold edge cases
    af_thresh = 5'd0;
    #1;
    cmp("af0_empty", 32'(s_af), 32'd1);
    af_thresh = 5'd17;
    for (int k = 0; k < 16; k++) cyc(1, 8'(8'h90 + k), 0, 0);
    cmp("af17_full", 32'(s_af), 32'd0);

    // Simultaneous at full: read accepted, write rejected
    cyc(1, 8'hCC, 1, 0);
    cmp("sf_fill", 32'(s_fill), 32'd15);
    cmp("sf_ovf",  32'(s_ovf),  32'd1);
    cmp("sf_rd",   32'(s_rd),   32'h90);
    af_thresh = 5'd14;
    cyc(0, 8'h00, 0, 1);

    // Reset mid-operation with 5 words stored
    for (int k = 0; k < 10; k++) cyc(0, 8'h00, 1, 0);
    cmp("pre_rst_fill", 32'(s_fill), 32'd5);
    #3;
    rst = 1'b0;
    #1;
    cmp("mrst_empty", 32'(s_empty), 32'd1);
    cmp("mrst_fill",  32'(s_fill),  32'd0);
    cmp("mrst_rd",    32'(s_rd),    32'd0);
    cmp("mrst_frd",   32'(f_rd),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1, 8'h3C, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cmp("post_rst_rd", 32'(s_rd),    32'h3C);
    cmp("post_rst_em", 32'(s_empty), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sfifo_thresh

// File: doc/sfifo_thresh.md
# sfifo_thresh

Single-clock, parametrised FIFO that generalises the team's async FIFO data path to one clock domain. It adds:
- run-time almost-full and almost-empty thresholds
- a live fill-level output
- sticky overflow/underflow error flags
- a selectable first-word-fall-through (FWFT) read mode

It sits between producer and consumer blocks sharing `clk`, and reuses the async FIFO's `wr_*`/`rd_*` port vocabulary so benches and interfaces carry over.

## Interface
Parameters:
- `DSIZE`, 8, data width in bits
- `ASIZE`, 4, address width; depth `DEPTH = 2**ASIZE`
- `FWFT`, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clk` externally)
- `wr_data`  in  `DSIZE`  write data
- `wr_inc`  in  1  write request
- `wr_full`  out  1  FIFO holds `DEPTH` words
- `wr_almost_full`  out  1  `fill_level >= af_thresh`
- `wr_overflow`  out  1  sticky: write attempted while full
- `rd_data`  out  `DSIZE`  read data
- `rd_inc`  in  1  read request / pop
- `rd_empty`  out  1  FIFO holds 0 words
- `rd_almost_empty`  out  1  `fill_level <= ae_thresh`
- `rd_underflow`  out  1  sticky: read attempted while empty
- `af_thresh`  in  `ASIZE+1`  almost-full threshold, quasi-static
- `ae_thresh`  in  `ASIZE+1`  almost-empty threshold, quasi-static
- `err_clr`  in  1  synchronous clear of both sticky flags
- `fill_level`  out  `ASIZE+1`  words currently stored, range 0..`DEPTH`

## Operation
- **Pointers:** `wr_ptr` and `rd_ptr` are `ASIZE+1` bits, binary. Memory is indexed by the low `ASIZE` bits; the MSB resolves wrap.
- **Fill level:** `fill_level = wr_ptr - rd_ptr` (modulo `2**(ASIZE+1)`).
- **Full:** `wr_full = (fill_level == DEPTH)`. **Empty:** `rd_empty = (fill_level == 0)`. All flags decode combinationally from the registered pointers.
- **Write:** accepted iff `wr_inc && !wr_full`. Stores `wr_data` at `wr_ptr[ASIZE-1:0]` and increments `wr_ptr`.
- **Read:** accepted iff `rd_inc && !rd_empty`. Increments `rd_ptr`.
- **Simultaneous read and write:**
  - Both are accepted independently and `fill_level` is unchanged.
  - When full, the read is accepted and the write is rejected, because the flag is sampled before the edge.
  - When empty, the write is accepted and the read is rejected.
- **Overflow:** `wr_inc && wr_full` sets `wr_overflow`. The write is dropped and memory and pointers are untouched.
- **Underflow:** `rd_inc && rd_empty` sets `rd_underflow`. `rd_ptr` and `rd_data` hold.
- **Clearing sticky flags:** `err_clr` clears both flags next edge. If a set condition occurs on the same edge, set wins.
- **Standard read (`FWFT=0`):** `rd_data` is a register loaded with `mem[rd_ptr]` on each accepted read. It holds otherwise.
- **FWFT read (`FWFT=1`):** `rd_data = mem[rd_ptr]` combinationally, valid whenever `!rd_empty`. `rd_inc` pops the head word.
- **Out-of-range thresholds:** values above `DEPTH` are legal. `af_thresh > DEPTH` means `wr_almost_full` is never set; `af_thresh = 0` means it is always set.

## Timing
- **Reset values:**
  - all pointers 0, `fill_level` = 0
  - `rd_empty` = 1, `wr_full` = 0
  - `wr_overflow` = 0, `rd_underflow` = 0
  - `rd_data` = 0
  - `rd_almost_empty` = 1
  - `wr_almost_full` = (`af_thresh == 0`)
- **Reset mid-operation:** contents are discarded. Memory need not be cleared, but it must be unreadable because `rd_empty` = 1.
- **Write-to-flag latency:** 1 cycle. A write on edge N makes `rd_empty` fall, and `fill_level` update, after edge N.
- **Standard read latency:** `rd_data` is valid after the edge on which the read was accepted.
- **FWFT read latency:** first word visible on `rd_data` the cycle after it is written into an empty FIFO.
- **Throughput:** one write and one read per cycle sustained, at any fill level except the full/empty blocking cases above.

## Structure
- **Package `sfifo_pkg`:** default `DSIZE`/`ASIZE` constants, and the read-mode localparams `RD_STD` = 0 and `RD_FWFT` = 1.
- **Sub-module `sfifo_mem`:** `DEPTH` x `DSIZE` dual-port RAM with a synchronous write port and an asynchronous read port.
- **Top level:** pointers, flags, sticky errors and the `rd_data` register live in `sfifo_thresh`.

## Test plan
Defaults throughout: `DSIZE`=8, `ASIZE`=4, `af_thresh`=14, `ae_thresh`=2.
- **Fill and drain:** write 0x00..0x0F back-to-back.
  - `wr_almost_full` rises after the 14th write; `wr_full` after the 16th; `fill_level` = 16.
  - 16 reads return 0x00..0x0F in order; `rd_almost_empty` rises when `fill_level` = 2; `rd_empty` = 1 at the end.
- **Overflow:** at full, `wr_inc` for 1 cycle.
  - `wr_overflow` = 1 and `fill_level` stays 16; read-back is unchanged.
  - `err_clr` pulse returns `wr_overflow` to 0.
- **Underflow:** after reset, `rd_inc` = 1.
  - `rd_underflow` = 1, `rd_data` stays 0x00, `fill_level` stays 0.
- **Simultaneous access and wrap:** hold `fill_level` = 8, then drive `wr_inc` and `rd_inc` every cycle for 40 cycles.
  - `fill_level` stays 8 and data order is preserved across pointer wrap.
- **FWFT:** with `FWFT`=1, write 0xA5 into the empty FIFO.
  - Next cycle `rd_data` = 0xA5 with no `rd_inc`.
  - One `rd_inc` leaves `rd_empty` = 1.
- **Reset mid-operation:** with 5 words stored, assert `rst` between edges.
  - Outputs take their reset values immediately (`rd_empty` = 1, `fill_level` = 0).
  - The next write/read pair returns the new word.
